if_stage_fetch: RTL and testbench

Instruction-fetch stage (pre-IF PC generation plus IF) of the 5-stage pipeline, directly upstream of the ID stage. Issues instruction requests on the SRAM-like bus (req/addr_ok/data_ok), holds at most one outstanding request, and buffers a returned instruction while ID refuses it. Handles branch and exception/ertn redirects, including discarding stale responses. Drives `if_ready_go` into ID's allow-in logic.

---
 rtl/if_stage_fetch_pkg.sv | 13 +
 rtl/if_inst_buf.sv | 74 +++++++
 rtl/if_stage_fetch.sv | 151 +++++++++++++++
 tb/tb_if_stage_fetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath widths,
// default boot address and the fixed bus transfer size.
package if_stage_fetch_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  // Instruction fetches are always full 32-bit words.
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/if_inst_buf.sv
// Response-side bookkeeping for the fetch stage: parks an instruction that
// ID is not ready to take, and tracks the single stale response that must be
// swallowed after a redirect.
module if_inst_buf
  import if_stage_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data_ok_i,
  input  logic [INST_W-1:0] rdata_i,
  input  logic              fs_waiting_i,  // response outstanding belongs to fs
  input  logic              id_allow_in_i,
  input  logic              handoff_i,     // fs instruction moves to ID now
  input  logic              cancel_i,      // redirect cancels the fs instruction
  input  logic              drop_accept_i, // request accepted this cycle is stale
  output logic              ibuf_valid_o,
  output logic [INST_W-1:0] ibuf_o,
  output logic              discard_o
);

  logic              ibuf_valid_q, ibuf_valid_d;
  logic [INST_W-1:0] ibuf_q, ibuf_d;
  logic              discard_q, discard_d;

  // Next-state for the buffer and the stale-response flag.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    ibuf_valid_d = ibuf_valid_q;
    ibuf_d       = ibuf_q;
    discard_d    = discard_q;

    // Park the instruction when it arrives but ID refuses it.
    if (data_ok_i && fs_waiting_i && !id_allow_in_i) begin
      ibuf_valid_d = 1'b1;
      ibuf_d       = rdata_i;
    end
    if (handoff_i || cancel_i) begin
      ibuf_valid_d = 1'b0;
    end

    // A response always retires the stale one, if any.
    if (data_ok_i) begin
      discard_d = 1'b0;
    end
    // A cancelled fetch whose data is still in flight, or a request accepted
    // after its address became wrong, leaves exactly one response to drop.
    if (drop_accept_i || (cancel_i && fs_waiting_i && !data_ok_i)) begin
      discard_d = 1'b1;
    end
  end

  // Control flags: cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ibuf_valid_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      ibuf_valid_q <= ibuf_valid_d;
      discard_q    <= discard_d;
    end
  end

  // Buffered instruction word.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; it is only ever read while ibuf_valid_q is set.
    ibuf_q <= ibuf_d;
  end

  assign ibuf_valid_o = ibuf_valid_q;
  assign ibuf_o       = ibuf_q;
  assign discard_o    = discard_q;

endmodule

// File: rtl/if_stage_fetch.sv
// Pre-IF PC generation plus IF stage. Keeps at most one instruction request
// outstanding on the SRAM-like bus, presents the returned word to ID with a
// zero-cycle bypass, and redirects on branches (ID) or exceptions/ertn (WB).
module if_stage_fetch
  import if_stage_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_allow_in,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_target,
  output logic              if_ready_go,
  output logic              if_to_id_valid,
  output logic [PC_W-1:0]   if_to_id_pc,
  output logic [INST_W-1:0] if_to_id_inst,
  output logic              inst_sram_req,
  output logic              inst_sram_wr,
  output logic [1:0]        inst_sram_size,
  output logic [PC_W-1:0]   inst_sram_addr,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  input  logic [INST_W-1:0] inst_sram_rdata
);

  logic [PC_W-1:0]   pfs_pc_q, pfs_pc_d;
  logic              fs_valid_q, fs_valid_d;
  logic [PC_W-1:0]   fs_pc_q, fs_pc_d;
  logic              fs_waiting_q, fs_waiting_d;
  logic              redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
  logic              req_hold_q, req_hold_d;

  logic              ibuf_valid;
  logic [INST_W-1:0] ibuf;
  logic              discard;

  logic              redirect;
  logic [PC_W-1:0]   redir_target;
  logic              data_fire;
  logic              handoff;
  logic              accept;
  logic              drop_accept;

  // WB redirects win over ID branches.
  assign redirect     = flush || br_taken;
  assign redir_target = flush ? flush_target : br_target;

  assign data_fire   = inst_sram_data_ok && fs_waiting_q;
  assign if_ready_go = fs_valid_q && (ibuf_valid || data_fire);
  assign handoff     = if_ready_go && id_allow_in;

  // A raised request is held until accepted; a new one is only issued when
  // no stale response is pending and fs is empty or emptying this cycle.
  assign inst_sram_req  = !rst && (req_hold_q || (!discard && (!fs_valid_q || handoff)));
  assign inst_sram_addr = pfs_pc_q;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = SIZE_WORD;

  assign accept      = inst_sram_req && inst_sram_addr_ok;
  // The accepted address is stale if a redirect arrives now or arrived while it was held.
  assign drop_accept = accept && (redirect || redir_valid_q);

  assign if_to_id_valid = if_ready_go && !redirect;
  assign if_to_id_pc    = fs_pc_q;
  assign if_to_id_inst  = ibuf_valid ? ibuf : (data_fire ? inst_sram_rdata : '0);

  if_inst_buf u_inst_buf (
    .clk           (clk),
    .rst           (rst),
    .data_ok_i     (inst_sram_data_ok),
    .rdata_i       (inst_sram_rdata),
    .fs_waiting_i  (fs_waiting_q),
    .id_allow_in_i (id_allow_in),
    .handoff_i     (handoff),
    .cancel_i      (redirect),
    .drop_accept_i (drop_accept),
    .ibuf_valid_o  (ibuf_valid),
    .ibuf_o        (ibuf),
    .discard_o     (discard)
  );

  // Next-state for PC generation, the fs slot and the deferred redirect.
  always_comb begin
    pfs_pc_d      = pfs_pc_q;
    fs_valid_d    = fs_valid_q;
    fs_pc_d       = fs_pc_q;
    fs_waiting_d  = fs_waiting_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    req_hold_d    = inst_sram_req && !inst_sram_addr_ok;

    if (handoff) begin
      fs_valid_d = 1'b0;
    end
    if (data_fire) begin
      fs_waiting_d = 1'b0;
    end

    if (accept) begin
      redir_valid_d = 1'b0;
      if (redir_valid_q) begin
        // Held request was for the old path: its response is dropped and
        // fetching resumes at the remembered target.
        pfs_pc_d = redir_pc_q;
      end else begin
        fs_valid_d   = 1'b1;
        fs_pc_d      = pfs_pc_q;
        fs_waiting_d = 1'b1;
        pfs_pc_d     = pfs_pc_q + PC_W'(4);
      end
    end

    if (redirect) begin
      fs_valid_d   = 1'b0;
      fs_waiting_d = 1'b0;
      if (!inst_sram_req || accept) begin
        pfs_pc_d = redir_target;
      end else begin
        // Address must stay stable while the request is held; remember the target.
        redir_valid_d = 1'b1;
        redir_pc_d    = redir_target;
      end
    end
  end

  // Fetch-stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pfs_pc_q      <= RESET_PC;
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= '0;
      fs_waiting_q  <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      req_hold_q    <= 1'b0;
    end else begin
      pfs_pc_q      <= pfs_pc_d;
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
      fs_waiting_q  <= fs_waiting_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      req_hold_q    <= req_hold_d;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: a bus responder with programmable latency, a
// program-order model of the PCs ID must see, and directed scenarios with
// hand-computed expectations.
module tb_if_stage_fetch;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_allow_in = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_target = '0;
  logic        if_ready_go;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_pc;
  logic [31:0] if_to_id_inst;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  if_stage_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .id_allow_in       (id_allow_in),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .flush             (flush),
    .flush_target      (flush_target),
    .if_ready_go       (if_ready_go),
    .if_to_id_valid    (if_to_id_valid),
    .if_to_id_pc       (if_to_id_pc),
    .if_to_id_inst     (if_to_id_inst),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Values applied at the next cycle start.
  logic        nxt_rst = 1'b1;
  logic        nxt_allow = 1'b0;
  logic        nxt_br = 1'b0;
  logic [31:0] nxt_br_target = '0;
  logic        nxt_flush = 1'b0;
  logic [31:0] nxt_flush_target = '0;
  logic        nxt_addr_ok = 1'b0;
  logic        stray = 1'b0;
  int          data_lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } pend_t;
  pend_t pend[$];
  int    cyc = 0;

  // Model state.
  logic [31:0] exp_pc = RESET_PC;
  int          outst = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  int n_cmp = 0;
  int n_fail = 0;

  localparam int W_DATA  = 0;
  localparam int W_REQ   = 1;
  localparam int W_DELIV = 2;

  // Memory contents the responder returns for an address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5a5a_5a5a;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle model check: program-order PCs, bus rules, cancellation.
  task automatic monitor();
    logic acc;
    if (rst) begin
      exp_pc    = RESET_PC;
      outst     = 0;
      prev_hold = 1'b0;
      return;
    end
    acc = inst_sram_req && inst_sram_addr_ok;
    check1("m_wr", inst_sram_wr, 1'b0);
    check32("m_size", {30'd0, inst_sram_size}, 32'd2);
    if (prev_hold) begin
      check1("m_req_stable", inst_sram_req, 1'b1);
      check32("m_addr_stable", inst_sram_addr, prev_addr);
    end
    if (flush || br_taken) check1("m_cancel", if_to_id_valid, 1'b0);
    if (if_to_id_valid && id_allow_in) begin
      check32("m_pc", if_to_id_pc, exp_pc);
      check32("m_inst", if_to_id_inst, inst_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (flush) exp_pc = flush_target;
    else if (br_taken) exp_pc = br_target;
    if (inst_sram_data_ok && outst > 0) outst--;
    if (acc) outst++;
    check1("m_outstanding", outst <= 1, 1'b1);
    prev_hold = inst_sram_req && !inst_sram_addr_ok;
    prev_addr = inst_sram_addr;
  endtask

  // One clock cycle: apply inputs, respond on the bus, check mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst               = nxt_rst;
    id_allow_in       = nxt_allow;
    br_taken          = nxt_br;
    br_target         = nxt_br_target;
    flush             = nxt_flush;
    flush_target      = nxt_flush_target;
    inst_sram_addr_ok = nxt_addr_ok;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'hdead_beef;
    if (stray) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = inst_of(32'h1c00_0404);
    end else if (pend.size() > 0 && (cyc - pend[0].cyc) >= data_lat) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = inst_of(pend[0].addr);
    end
    @(negedge clk);
    monitor();
    if (inst_sram_data_ok && pend.size() > 0) void'(pend.pop_front());
    if (inst_sram_req && inst_sram_addr_ok) pend.push_back('{addr: inst_sram_addr, cyc: cyc});
    if (rst) pend.delete();
  endtask

  task automatic run_until(input int what, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      case (what)
        W_DATA:  hit = inst_sram_data_ok;
        W_REQ:   hit = inst_sram_req;
        default: hit = if_to_id_valid && id_allow_in;
      endcase
    end
    check1({name, "_reached"}, hit, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_req"}, inst_sram_req, 1'b0);
    check1({tag, "_ready_go"}, if_ready_go, 1'b0);
    check1({tag, "_to_id_valid"}, if_to_id_valid, 1'b0);
    check32({tag, "_pc"}, if_to_id_pc, 32'h0);
    check32({tag, "_inst"}, if_to_id_inst, 32'h0);
    check32({tag, "_addr"}, inst_sram_addr, 32'h1c00_0000);
    check1({tag, "_wr"}, inst_sram_wr, 1'b0);
    check32({tag, "_size"}, {30'd0, inst_sram_size}, 32'd2);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    check_reset_outputs("rst0");

    // Back-to-back fetch, 1-cycle bus.
    nxt_rst = 1'b0; nxt_addr_ok = 1'b1; nxt_allow = 1'b1; data_lat = 1;
    tick();
    check1("first_req", inst_sram_req, 1'b1);
    check32("first_addr", inst_sram_addr, 32'h1c00_0000);
    tick();
    check1("b2b0_valid", if_to_id_valid, 1'b1);
    check32("b2b0_pc", if_to_id_pc, 32'h1c00_0000);
    check32("b2b0_inst", if_to_id_inst, 32'h465a_5a5a);
    tick();
    check1("b2b1_valid", if_to_id_valid, 1'b1);
    check32("b2b1_pc", if_to_id_pc, 32'h1c00_0004);
    tick();
    check1("b2b2_valid", if_to_id_valid, 1'b1);
    check32("b2b2_pc", if_to_id_pc, 32'h1c00_0008);

    // ID stalls: word for 1c00000c parks in the buffer, no new request.
    nxt_allow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("stall_req", inst_sram_req, 1'b0);
      check1("stall_ready", if_ready_go, 1'b1);
      check32("stall_inst", if_to_id_inst, 32'h465a_5a56);
    end
    nxt_allow = 1'b1;
    tick();
    check1("release_valid", if_to_id_valid, 1'b1);
    check32("release_pc", if_to_id_pc, 32'h1c00_000c);
    check32("release_inst", if_to_id_inst, 32'h465a_5a56);
    tick();
    check32("after_release_pc", if_to_id_pc, 32'h1c00_0010);

    // Branch while fs waits for data (slow bus).
    data_lat = 3;
    nxt_br = 1'b1; nxt_br_target = 32'h1c00_0100;
    tick();
    check1("br_ready", if_ready_go, 1'b0);
    nxt_br = 1'b0;
    run_until(W_DATA, "br_stale");
    check1("br_stale_valid", if_to_id_valid, 1'b0);
    check1("br_stale_ready", if_ready_go, 1'b0);
    run_until(W_REQ, "br_req");
    check32("br_addr", inst_sram_addr, 32'h1c00_0100);

    // Flush while a request is held without addr_ok.
    nxt_addr_ok = 1'b0;
    run_until(W_DELIV, "br_deliv");
    check32("br_pc", if_to_id_pc, 32'h1c00_0100);
    check1("hold_req0", inst_sram_req, 1'b1);
    check32("hold_addr0", inst_sram_addr, 32'h1c00_0104);
    nxt_flush = 1'b1; nxt_flush_target = 32'h1c00_8000;
    tick();
    check1("hold_req1", inst_sram_req, 1'b1);
    check32("hold_addr1", inst_sram_addr, 32'h1c00_0104);
    nxt_flush = 1'b0;
    tick();
    check32("hold_addr2", inst_sram_addr, 32'h1c00_0104);
    data_lat = 1; nxt_addr_ok = 1'b1;
    tick();
    check1("hold_accept_req", inst_sram_req, 1'b1);
    check32("hold_accept_addr", inst_sram_addr, 32'h1c00_0104);
    run_until(W_DATA, "fl_stale");
    check1("fl_stale_valid", if_to_id_valid, 1'b0);
    run_until(W_REQ, "fl_req");
    check32("fl_addr", inst_sram_addr, 32'h1c00_8000);
    run_until(W_DELIV, "fl_deliv");
    check32("fl_pc", if_to_id_pc, 32'h1c00_8000);

    // Flush and branch together: flush target wins.
    nxt_flush = 1'b1; nxt_flush_target = 32'h1c00_0400;
    nxt_br = 1'b1; nxt_br_target = 32'h1c00_0800;
    tick();
    check1("both_ready", if_ready_go, 1'b1);
    check1("both_valid", if_to_id_valid, 1'b0);
    nxt_flush = 1'b0; nxt_br = 1'b0;
    run_until(W_REQ, "both_req");
    check32("both_addr", inst_sram_addr, 32'h1c00_0400);
    run_until(W_DELIV, "both_deliv");
    check32("both_pc", if_to_id_pc, 32'h1c00_0400);

    // Reset with a request outstanding, then a stray response.
    data_lat = 4;
    nxt_rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst1");
    nxt_rst = 1'b0; stray = 1'b1; data_lat = 1;
    tick();
    stray = 1'b0;
    check1("stray_ready", if_ready_go, 1'b0);
    check1("stray_valid", if_to_id_valid, 1'b0);
    check1("restart_req", inst_sram_req, 1'b1);
    check32("restart_addr", inst_sram_addr, 32'h1c00_0000);
    tick();
    check1("restart_valid", if_to_id_valid, 1'b1);
    check32("restart_pc", if_to_id_pc, 32'h1c00_0000);
    check32("restart_inst", if_to_id_inst, 32'h465a_5a5a);
    for (int i = 0; i < 4; i++) tick();
    check32("final_pc", if_to_id_pc, 32'h1c00_0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
